// File: rtl/acumulador_puntuacion.sv
// Running score accumulator for the drum game: turns perfect/good/miss judgements into a
// saturating 13-bit score with a combo-driven multiplier, plus the ESPERA/JUGANDO/FIN game FSM.
//
//  state   | meaning
//  ESPERA  | idle after reset, waiting for the first inicio (standBy=1)
//  JUGANDO | song in progress, hit judgements are scored
//  FIN     | song over, score frozen for high-score capture

module acumulador_puntuacion #(
    parameter int unsigned PUNTOS_PERFECTO = 10,
    parameter int unsigned PUNTOS_BUENO    = 5,
    parameter int unsigned COMBO_PASO      = 4,
    parameter int unsigned MULT_MAX        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inicio,
    input  logic        fin,
    input  logic        golpePerfecto,
    input  logic        golpeBueno,
    input  logic        golpeFallo,
    output logic [12:0] puntuacion,
    output logic [6:0]  combo,
    output logic [2:0]  multiplicador,
    output logic        actualizado,
    output logic        saturado,
    output logic        standBy
);

    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        JUGANDO = 2'd1,
        FIN     = 2'd2
    } estado_t;

    localparam logic [12:0] PUNT_MAX  = 13'h1FFF;
    localparam logic [6:0]  COMBO_MAX = 7'd127;

    estado_t     estado, estado_sig;
    logic [12:0] puntuacion_sig;
    logic [6:0]  combo_sig, combo_inc;
    logic [2:0]  mult_sig;
    logic        act_sig, sat_sig;
    logic [5:0]  base, pts;
    logic [13:0] suma;
    int unsigned mult_calc;

    always_ff @(posedge clk) begin
        if (reset) begin
            estado        <= ESPERA;
            puntuacion    <= '0;
            combo         <= '0;
            multiplicador <= 3'd1;
            actualizado   <= 1'b0;
            saturado      <= 1'b0;
        end else begin
            estado        <= estado_sig;
            puntuacion    <= puntuacion_sig;
            combo         <= combo_sig;
            multiplicador <= mult_sig;
            actualizado   <= act_sig;
            saturado      <= sat_sig;
        end
    end

    always_comb begin
        estado_sig     = estado;
        puntuacion_sig = puntuacion;
        combo_sig      = combo;
        mult_sig       = multiplicador;
        act_sig        = 1'b0;
        sat_sig        = saturado;

        // 14-bit sum so an overflow past 8191 is visible before clamping
        base      = golpePerfecto ? 6'(PUNTOS_PERFECTO) : 6'(PUNTOS_BUENO);
        pts       = base * 6'(multiplicador);
        suma      = {1'b0, puntuacion} + {8'd0, pts};
        combo_inc = (combo == COMBO_MAX) ? COMBO_MAX : combo + 7'd1;
        mult_calc = 1 + 32'(combo_inc) / COMBO_PASO;

        if (inicio) begin
            estado_sig     = JUGANDO;
            puntuacion_sig = '0;
            combo_sig      = '0;
            mult_sig       = 3'd1;
            sat_sig        = 1'b0;
        end else if (estado == JUGANDO) begin
            if (fin) begin
                estado_sig = FIN;
            end else if (golpeFallo) begin
                combo_sig = '0;
                mult_sig  = 3'd1;
            end else if (golpePerfecto || golpeBueno) begin
                if (suma > {1'b0, PUNT_MAX}) begin
                    puntuacion_sig = PUNT_MAX;
                    sat_sig        = 1'b1;
                end else begin
                    puntuacion_sig = suma[12:0];
                end
                act_sig   = (puntuacion_sig != puntuacion);
                combo_sig = combo_inc;
                mult_sig  = (mult_calc > MULT_MAX) ? 3'(MULT_MAX) : 3'(mult_calc);
            end
        end
    end

    assign standBy = (estado == ESPERA);

endmodule

// File: tb/tb_acumulador_puntuacion.sv
// Directed bench for acumulador_puntuacion: reset, scoring, miss/priority, clamp, restart, mid-game reset.

module tb_acumulador_puntuacion;

    logic        clk = 1'b0;
    logic        reset, inicio, fin, golpePerfecto, golpeBueno, golpeFallo;
    logic [12:0] puntuacion;
    logic [6:0]  combo;
    logic [2:0]  multiplicador;
    logic        actualizado, saturado, standBy;

    int total = 0;
    int bad = 0;
    int act_count = 0;

    int m_score, m_combo, m_mult, m_sum, m_prev;
    logic m_act;
    bit clamped;

    acumulador_puntuacion dut (
        .clk           (clk),
        .reset         (reset),
        .inicio        (inicio),
        .fin           (fin),
        .golpePerfecto (golpePerfecto),
        .golpeBueno    (golpeBueno),
        .golpeFallo    (golpeFallo),
        .puntuacion    (puntuacion),
        .combo         (combo),
        .multiplicador (multiplicador),
        .actualizado   (actualizado),
        .saturado      (saturado),
        .standBy       (standBy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // drive one cycle of inputs, sample 1 ns after the edge, then release the pulses
    task automatic step(input logic r, input logic ini, input logic f,
                        input logic gp, input logic gb, input logic gf);
        reset = r; inicio = ini; fin = f;
        golpePerfecto = gp; golpeBueno = gb; golpeFallo = gf;
        @(posedge clk);
        #1;
        if (actualizado === 1'b1) act_count++;
        reset = 1'b0; inicio = 1'b0; fin = 1'b0;
        golpePerfecto = 1'b0; golpeBueno = 1'b0; golpeFallo = 1'b0;
    endtask

    initial begin
        reset = 1'b1; inicio = 1'b0; fin = 1'b0;
        golpePerfecto = 1'b0; golpeBueno = 1'b0; golpeFallo = 1'b0;

        // 1: reset and idle; a hit while waiting is ignored
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0);
        chk("rst_punt", 32'(puntuacion), 0);
        chk("rst_combo", 32'(combo), 0);
        chk("rst_mult", 32'(multiplicador), 1);
        chk("rst_standby", 32'(standBy), 1);
        chk("rst_sat", 32'(saturado), 0);
        step(0, 0, 0, 1, 0, 0);
        chk("espera_ignora", 32'(puntuacion), 0);

        // 2: five perfects -> 10,10,10,10,20
        step(0, 1, 0, 1, 0, 0);
        chk("inicio_ignora_golpe", 32'(puntuacion), 0);
        chk("jugando_standby", 32'(standBy), 0);
        act_count = 0;
        step(0, 0, 0, 1, 0, 0);
        chk("p1_punt", 32'(puntuacion), 10);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("p4_punt", 32'(puntuacion), 40);
        chk("p4_mult", 32'(multiplicador), 2);
        step(0, 0, 0, 1, 0, 0);
        chk("p5_punt", 32'(puntuacion), 60);
        chk("p5_combo", 32'(combo), 5);
        chk("p5_mult", 32'(multiplicador), 2);
        step(0, 0, 0, 0, 0, 0);
        chk("idle_act", 32'(actualizado), 0);
        step(0, 0, 0, 0, 0, 0);
        chk("act_count", 32'(act_count), 5);

        // 3: miss then good
        step(0, 0, 0, 0, 0, 1);
        chk("miss_combo", 32'(combo), 0);
        chk("miss_mult", 32'(multiplicador), 1);
        chk("miss_punt", 32'(puntuacion), 60);
        chk("miss_act", 32'(actualizado), 0);
        step(0, 0, 0, 0, 1, 0);
        chk("bueno_punt", 32'(puntuacion), 65);
        chk("bueno_combo", 32'(combo), 1);

        // 4: priority
        step(0, 0, 0, 1, 0, 1);
        chk("prio_fallo_punt", 32'(puntuacion), 65);
        chk("prio_fallo_combo", 32'(combo), 0);
        step(0, 0, 0, 1, 1, 0);
        chk("prio_perf_punt", 32'(puntuacion), 75);
        chk("prio_perf_combo", 32'(combo), 1);

        // 5: perfect hits until the score clamps
        m_score = 75; m_combo = 1; m_mult = 1; clamped = 0;
        for (int i = 0; i < 400 && !clamped; i++) begin
            m_prev  = m_score;
            m_sum   = m_score + 10 * m_mult;
            clamped = (m_sum > 8191);
            m_score = clamped ? 8191 : m_sum;
            m_act   = (m_score != m_prev);
            m_combo = (m_combo == 127) ? 127 : m_combo + 1;
            m_mult  = (1 + m_combo / 4 > 4) ? 4 : 1 + m_combo / 4;
            step(0, 0, 0, 1, 0, 0);
            chk("sat_loop_punt", 32'(puntuacion), 32'(m_score));
            chk("sat_loop_act", 32'(actualizado), 32'(m_act));
        end
        chk("sat_reached", 32'(clamped), 1);
        chk("sat_punt", 32'(puntuacion), 8191);
        chk("sat_flag", 32'(saturado), 1);
        chk("sat_combo127", 32'(combo), 127);
        chk("sat_mult", 32'(multiplicador), 4);
        step(0, 0, 0, 1, 0, 0);
        chk("post_sat_punt", 32'(puntuacion), 8191);
        chk("post_sat_act", 32'(actualizado), 0);
        chk("post_sat_flag", 32'(saturado), 1);
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("fin_punt", 32'(puntuacion), 8191);
        chk("fin_act", 32'(actualizado), 0);
        chk("fin_combo", 32'(combo), 127);
        chk("fin_standby", 32'(standBy), 0);
        step(0, 1, 0, 0, 0, 0);
        chk("restart_punt", 32'(puntuacion), 0);
        chk("restart_sat", 32'(saturado), 0);
        chk("restart_combo", 32'(combo), 0);
        chk("restart_mult", 32'(multiplicador), 1);

        // 6: reset mid-game with a simultaneous hit
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("pre_rst_punt", 32'(puntuacion), 15);
        step(1, 0, 0, 1, 0, 0);
        chk("midrst_punt", 32'(puntuacion), 0);
        chk("midrst_combo", 32'(combo), 0);
        chk("midrst_mult", 32'(multiplicador), 1);
        chk("midrst_act", 32'(actualizado), 0);
        chk("midrst_sat", 32'(saturado), 0);
        chk("midrst_standby", 32'(standBy), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
